// File: rtl/controlpath_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : controlpath_multi_if
// Brief    : Control bundle between the multi-cycle FSM and datapath/memories.
// Revision : 1.0
// ============================================================================
interface controlpath_multi_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           inst_opcode;
    logic [2:0]           inst_funct3;
    logic                 alu_rd_equals_zero;
    logic                 imem_ready;
    logic                 dmem_ready;
    logic                 imem_req;
    logic                 ir_wren;
    logic                 alu_out_wren;
    logic [1:0]           alu_op_raw;
    logic                 alu_op_a_sel;
    logic                 alu_op_b_sel;
    logic                 mem_rd_en;
    logic                 mem_wr_en;
    logic                 reg_file_wen;
    logic                 pc_wren;
    logic                 sel_next_pc;
    logic                 illegal_inst;
    logic                 bus_err;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  inst_opcode, inst_funct3, alu_rd_equals_zero, imem_ready, dmem_ready,
        output imem_req, ir_wren, alu_out_wren, alu_op_raw, alu_op_a_sel, alu_op_b_sel,
               mem_rd_en, mem_wr_en, reg_file_wen, pc_wren, sel_next_pc,
               illegal_inst, bus_err, instret
    );

    modport slave (
        output inst_opcode, inst_funct3, alu_rd_equals_zero, imem_ready, dmem_ready,
        input  imem_req, ir_wren, alu_out_wren, alu_op_raw, alu_op_a_sel, alu_op_b_sel,
               mem_rd_en, mem_wr_en, reg_file_wen, pc_wren, sel_next_pc,
               illegal_inst, bus_err, instret
    );
endinterface
`default_nettype wire

// File: rtl/controlpath_multi.sv
`default_nettype none
// ============================================================================
// Module   : controlpath_multi
// Brief    : Multi-cycle RV32I control FSM with wait-state handshakes and traps.
// Revision : 1.0
// ============================================================================
module controlpath_multi #(
    parameter int BUS_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    controlpath_multi_if.master bus
);
    localparam int c_TO_W = $clog2(BUS_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(BUS_TIMEOUT - 1);

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic [INSTRET_W-1:0] r_instret;
    logic                 r_illegal;
    logic                 r_bus_err;

    logic       w_is_load, w_is_store, w_is_op, w_is_op_imm, w_is_branch, w_legal;
    logic       w_take;
    logic       w_wait_low, w_timeout;
    logic       w_set_illegal, w_set_bus_err;
    logic       w_alu_drive;
    logic [1:0] w_raw_dec;
    logic       w_bsel_dec;

    logic       w_imem_req, w_ir_wren, w_alu_out_wren, w_mem_rd_en, w_mem_wr_en;
    logic       w_reg_file_wen, w_pc_wren, w_sel_next_pc;

    assign w_is_load   = (bus.inst_opcode == c_OPC_LOAD);
    assign w_is_store  = (bus.inst_opcode == c_OPC_STORE);
    assign w_is_op     = (bus.inst_opcode == c_OPC_OP);
    assign w_is_op_imm = (bus.inst_opcode == c_OPC_OP_IMM);
    assign w_is_branch = (bus.inst_opcode == c_OPC_BRANCH);
    assign w_legal     = w_is_load | w_is_store | w_is_op | w_is_op_imm | w_is_branch;

    // The ALU result is nonzero iff the base compare holds; odd funct3 inverts the sense.
    always_comb begin
        w_take = 1'b0;
        case (bus.inst_funct3)
            3'b000, 3'b100, 3'b110: w_take = ~bus.alu_rd_equals_zero;
            3'b001, 3'b101, 3'b111: w_take = bus.alu_rd_equals_zero;
            default:                w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_raw_dec  = 2'b00;
        w_bsel_dec = 1'b1;
        if (w_is_op) begin
            w_raw_dec  = 2'b01;
            w_bsel_dec = 1'b0;
        end else if (w_is_op_imm) begin
            w_raw_dec  = 2'b10;
            w_bsel_dec = 1'b1;
        end else if (w_is_branch) begin
            w_raw_dec  = 2'b11;
            w_bsel_dec = 1'b0;
        end
    end

    // Ready wins over timeout on the last permitted cycle.
    assign w_wait_low = ((r_state == ST_FETCH) && !bus.imem_ready) ||
                        ((r_state == ST_MEM)   && !bus.dmem_ready);
    assign w_timeout  = w_wait_low && (r_to_cnt == c_TO_LAST);

    always_comb begin
        w_next         = r_state;
        w_imem_req     = 1'b0;
        w_ir_wren      = 1'b0;
        w_alu_out_wren = 1'b0;
        w_mem_rd_en    = 1'b0;
        w_mem_wr_en    = 1'b0;
        w_reg_file_wen = 1'b0;
        w_pc_wren      = 1'b0;
        w_sel_next_pc  = 1'b0;
        w_alu_drive    = 1'b0;
        w_set_illegal  = 1'b0;
        w_set_bus_err  = 1'b0;
        case (r_state)
            ST_BOOT: w_next = ST_FETCH;
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_wren = 1'b1;
                    w_next    = ST_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (w_legal) begin
                    w_next = ST_EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = ST_TRAP;
                end
            end
            ST_EXEC: begin
                w_alu_out_wren = 1'b1;
                w_alu_drive    = 1'b1;
                if (w_is_load || w_is_store) begin
                    w_next = ST_MEM;
                end else if (w_is_branch) begin
                    w_pc_wren     = 1'b1;
                    w_sel_next_pc = w_take;
                    w_next        = ST_FETCH;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                w_alu_drive = 1'b1;
                w_mem_rd_en = w_is_load;
                w_mem_wr_en = w_is_store;
                if (bus.dmem_ready) begin
                    if (w_is_load) begin
                        w_next = ST_WB;
                    end else begin
                        w_pc_wren = 1'b1;
                        w_next    = ST_FETCH;
                    end
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = ST_TRAP;
                end
            end
            ST_WB: begin
                w_alu_drive    = 1'b1;
                w_reg_file_wen = 1'b1;
                w_pc_wren      = 1'b1;
                w_next         = ST_FETCH;
            end
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_BOOT;
            r_to_cnt  <= '0;
            r_instret <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_wait_low) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_pc_wren) begin
                r_instret <= r_instret + 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus.imem_req     = w_imem_req;
    assign bus.ir_wren      = w_ir_wren;
    assign bus.alu_out_wren = w_alu_out_wren;
    assign bus.alu_op_raw   = w_alu_drive ? w_raw_dec : 2'b00;
    assign bus.alu_op_a_sel = 1'b0;
    assign bus.alu_op_b_sel = w_alu_drive ? w_bsel_dec : 1'b0;
    assign bus.mem_rd_en    = w_mem_rd_en;
    assign bus.mem_wr_en    = w_mem_wr_en;
    assign bus.reg_file_wen = w_reg_file_wen;
    assign bus.pc_wren      = w_pc_wren;
    assign bus.sel_next_pc  = w_sel_next_pc;
    assign bus.illegal_inst = r_illegal;
    assign bus.bus_err      = r_bus_err;
    assign bus.instret      = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_controlpath_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlpath_multi
// Brief    : Scoreboard bench for controlpath_multi with a memory/datapath model.
// Revision : 1.0
// ============================================================================
module tb_controlpath_multi;
    localparam int c_TO = 16;
    localparam int c_IW = 4;

    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          iw;
        int          dw;
    } stim_t;

    typedef struct {
        logic [1:0] raw;
        logic       bsel;
        logic       regw;
        logic       take;
        int         cpi;
        int         rd;
        int         wr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   sb_on;
    bit   in_fetch;
    int   iw_left;
    int   dw_left;
    stim_t stim_q[$];
    exp_t  exp_q[$];

    controlpath_multi_if #(.INSTRET_W(c_IW)) bus ();

    controlpath_multi #(
        .BUS_TIMEOUT (c_TO),
        .INSTRET_W   (c_IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred with no matching expectation", name);
    endtask

    function automatic logic [13:0] outs();
        return {bus.imem_req, bus.ir_wren, bus.alu_out_wren, bus.alu_op_raw,
                bus.alu_op_a_sel, bus.alu_op_b_sel, bus.mem_rd_en, bus.mem_wr_en,
                bus.reg_file_wen, bus.pc_wren, bus.sel_next_pc, bus.illegal_inst, bus.bus_err};
    endfunction

    // Datapath model: the ALU compares with eq/slt/sltu and yields nonzero iff it holds.
    function automatic logic alu_zero(input stim_t s);
        logic cmp;
        case (s.f3[2:1])
            2'b10:   cmp = ($signed(s.a) < $signed(s.b));
            2'b11:   cmp = (s.a < s.b);
            default: cmp = (s.a == s.b);
        endcase
        return !cmp;
    endfunction

    function automatic logic branch_taken(input stim_t s);
        case (s.f3)
            3'b000:  return s.a == s.b;
            3'b001:  return s.a != s.b;
            3'b100:  return $signed(s.a) <  $signed(s.b);
            3'b101:  return $signed(s.a) >= $signed(s.b);
            3'b110:  return s.a <  s.b;
            3'b111:  return s.a >= s.b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        e.take = 1'b0; e.rd = 0; e.wr = 0;
        case (s.opc)
            c_LOAD:   begin e.raw = 2'b00; e.bsel = 1'b1; e.regw = 1'b1; e.cpi = 5 + s.iw + s.dw; e.rd = s.dw + 1; end
            c_STORE:  begin e.raw = 2'b00; e.bsel = 1'b1; e.regw = 1'b0; e.cpi = 4 + s.iw + s.dw; e.wr = s.dw + 1; end
            c_OP:     begin e.raw = 2'b01; e.bsel = 1'b0; e.regw = 1'b1; e.cpi = 4 + s.iw; end
            c_OP_IMM: begin e.raw = 2'b10; e.bsel = 1'b1; e.regw = 1'b1; e.cpi = 4 + s.iw; end
            default:  begin e.raw = 2'b11; e.bsel = 1'b0; e.regw = 1'b0; e.cpi = 3 + s.iw; e.take = branch_taken(s); end
        endcase
        return e;
    endfunction

    task automatic push_stim(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input int iw, input int dw);
        stim_t s;
        s.opc = opc; s.f3 = f3; s.a = a; s.b = b; s.iw = iw; s.dw = dw;
        stim_q.push_back(s);
    endtask

    // Memory model: one call per cycle, just after the falling edge.
    task automatic drive_cycle();
        stim_t s;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        if (bus.imem_req) begin
            if (!in_fetch && stim_q.size() > 0) begin
                s = stim_q.pop_front();
                bus.inst_opcode        = s.opc;
                bus.inst_funct3        = s.f3;
                bus.alu_rd_equals_zero = alu_zero(s);
                iw_left  = s.iw;
                dw_left  = s.dw;
                in_fetch = 1'b1;
                exp_q.push_back(model(s));
            end
            if (in_fetch) begin
                if (iw_left == 0) begin
                    bus.imem_ready = 1'b1;
                    in_fetch       = 1'b0;
                end else begin
                    iw_left--;
                end
            end
        end
        if (bus.mem_rd_en || bus.mem_wr_en) begin
            if (dw_left == 0) bus.dmem_ready = 1'b1;
            else dw_left--;
        end
    endtask

    task automatic do_reset(input bit sb);
        rst_n = 1'b0;
        sb_on = 1'b0;
        in_fetch = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_on = sb;
    endtask

    task automatic run_phase(input int n_inst);
        int c;
        do_reset(1'b1);
        c = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && c < n_inst * 40) begin
            @(negedge clk);
            drive_cycle();
            #2;
            c++;
        end
        if (c >= n_inst * 40) begin
            n_tests++; n_fail++;
            $display("FAIL phase_budget: got %0d cycles expected under %0d", c, n_inst * 40);
        end
        @(negedge clk);
        drive_cycle();
        #2;
        check("phase_instret", 32'(bus.instret), 32'(n_inst % (1 << c_IW)));
        check("phase_flags", {bus.illegal_inst, bus.bus_err}, 0);
        rst_n = 1'b0;
        sb_on = 1'b0;
        stim_q.delete();
    endtask

    // Monitor: compares on EXEC (alu_out_wren) and on every retire (pc_wren).
    initial begin
        int   cyc, rd_cnt, wr_cnt, retired;
        bit   first;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!sb_on) begin
                cyc = 0; rd_cnt = 0; wr_cnt = 0; retired = 0; first = 1'b1;
                exp_q.delete();
            end else begin
                cyc++;
                if (bus.mem_rd_en) rd_cnt++;
                if (bus.mem_wr_en) wr_cnt++;
                if (bus.alu_out_wren) begin
                    if (exp_q.size() == 0) begin
                        report_fail("exec_unexpected");
                    end else begin
                        e = exp_q[0];
                        check("exec_alu_raw", bus.alu_op_raw, e.raw);
                        check("exec_alu_sel", {bus.alu_op_a_sel, bus.alu_op_b_sel}, {1'b0, e.bsel});
                    end
                end
                if (bus.pc_wren) begin
                    if (exp_q.size() == 0) begin
                        report_fail("retire_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("retire_instret", 32'(bus.instret), 32'(retired % (1 << c_IW)));
                        check("retire_sel_next_pc", bus.sel_next_pc, e.take);
                        check("retire_reg_wen", bus.reg_file_wen, e.regw);
                        check("retire_cycles", cyc, e.cpi + (first ? 1 : 0));
                        check("retire_mem_rd_cycles", rd_cnt, e.rd);
                        check("retire_mem_wr_cycles", wr_cnt, e.wr);
                    end
                    retired++;
                    first = 1'b0;
                    cyc = 0; rd_cnt = 0; wr_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt, seen;
        logic [31:0] ops [3];
        n_tests = 0; n_fail = 0; sb_on = 1'b0; in_fetch = 1'b0; iw_left = 0; dw_left = 0;
        rst_n = 1'b0;
        bus.inst_opcode = c_OP; bus.inst_funct3 = 3'b000; bus.alu_rd_equals_zero = 1'b0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outputs", outs(), 0);
        check("reset_instret", 32'(bus.instret), 0);

        // Illegal opcode traps after DECODE and stops fetching.
        do_reset(1'b0);
        bus.inst_opcode = 7'b1111111; bus.imem_ready = 1'b1;
        @(negedge clk); #1; check("boot_outputs", outs(), 0);
        @(negedge clk); #1; check("first_fetch", {bus.imem_req, bus.ir_wren}, 2'b11);
        @(negedge clk); #1; check("decode_idle", outs(), 0);
        @(negedge clk); #1; check("illegal_flag", bus.illegal_inst, 1);
        cnt = 0;
        repeat (10) begin @(negedge clk); #1; if (bus.imem_req) cnt++; end
        check("trap_no_fetch", cnt, 0);
        rst_n = 1'b0; #1;
        check("illegal_cleared", bus.illegal_inst, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); #1; check("restart_boot", bus.imem_req, 0);
        @(negedge clk); #1; check("restart_fetch", bus.imem_req, 1);

        // Fetch timeout after exactly BUS_TIMEOUT cycles.
        do_reset(1'b0);
        bus.inst_opcode = c_OP;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.imem_req) cnt++;
            else if (cnt > 0) break;
        end
        check("timeout_fetch_cycles", cnt, c_TO);
        check("timeout_bus_err", bus.bus_err, 1);
        repeat (3) @(negedge clk);
        #1; check("timeout_trap_idle", {bus.imem_req, bus.bus_err}, 2'b01);

        // Ready arriving on the last permitted cycle completes normally.
        do_reset(1'b0);
        bus.inst_opcode = c_OP;
        cnt = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.imem_ready = 1'b0;
            if (bus.imem_req) begin
                cnt++;
                if (cnt == c_TO) bus.imem_ready = 1'b1;
            end
            #1;
            if (bus.ir_wren) begin seen = cnt; break; end
        end
        check("late_ready_cycle", seen, c_TO);
        @(negedge clk); bus.imem_ready = 1'b0; #1;
        check("late_ready_decode", {bus.bus_err, bus.imem_req}, 0);
        @(negedge clk); #1;
        check("late_ready_exec", {bus.alu_out_wren, bus.alu_op_raw}, 3'b101);

        // Reset asserted during a STORE's MEM phase aborts it.
        do_reset(1'b0);
        bus.inst_opcode = c_OP; bus.imem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.pc_wren) begin bus.inst_opcode = c_STORE; break; end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.mem_wr_en) break;
        end
        check("store_mem_wr", {bus.mem_wr_en, bus.alu_op_b_sel}, 2'b11);
        check("store_instret_before", 32'(bus.instret), 1);
        rst_n = 1'b0; #1;
        check("abort_outputs", outs(), 0);
        check("abort_instret", 32'(bus.instret), 0);

        // Scoreboard phases.
        push_stim(c_OP, 3'b000, 0, 0, 0, 0);
        run_phase(1);

        push_stim(c_LOAD, 3'b010, 0, 0, 0, 3);
        run_phase(1);

        ops[0] = 32'd5; ops[1] = 32'hFFFF_FFFE; ops[2] = 32'd3;
        for (int f = 0; f < 8; f++) begin
            push_stim(c_BRANCH, 3'(f), ops[0], ops[0], 0, 0);
            push_stim(c_BRANCH, 3'(f), ops[1], ops[2], 0, 0);
            push_stim(c_BRANCH, 3'(f), ops[2], ops[1], 0, 0);
        end
        run_phase(24);

        for (int i = 0; i < 17; i++) push_stim(c_OP_IMM, 3'(i), 0, 0, $urandom_range(0, 2), 0);
        run_phase(17);

        for (int i = 0; i < 60; i++) begin
            logic [6:0] opc;
            int iw, dw;
            case ($urandom_range(0, 4))
                0: opc = c_LOAD;
                1: opc = c_STORE;
                2: opc = c_OP;
                3: opc = c_OP_IMM;
                default: opc = c_BRANCH;
            endcase
            iw = ($urandom_range(0, 7) == 0) ? c_TO - 1 : $urandom_range(0, 3);
            dw = ($urandom_range(0, 7) == 0) ? c_TO - 1 : $urandom_range(0, 3);
            push_stim(opc, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 3)) - 32'd1,
                      32'($urandom_range(0, 3)) - 32'd1, iw, dw);
        end
        run_phase(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
